// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_if
// Purpose  : MEM->WB handshake, register-file write port and decode bypass
//            bundle for the writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_stage_if #(
    parameter int DW = 16,
    parameter int RW = 3,
    parameter int CW = 16
);
    // MEM stage side
    logic          in_valid;
    logic          in_ready;
    logic          in_regwrite;
    logic [1:0]    in_wbsel;
    logic [RW-1:0] in_wreg;
    logic [DW-1:0] in_alu;
    logic [DW-1:0] in_pc2;
    logic [DW-1:0] in_imm;
    logic          in_halt;
    logic          dmem_done;
    logic [DW-1:0] dmem_data;
    // register file write port
    logic          write;
    logic [RW-1:0] writeregsel;
    logic [DW-1:0] writedata;
    // decode read bypass
    logic [RW-1:0] rd1sel;
    logic [RW-1:0] rd2sel;
    logic [DW-1:0] rd1_rf;
    logic [DW-1:0] rd2_rf;
    logic [DW-1:0] rd1_fwd;
    logic [DW-1:0] rd2_fwd;
    // status
    logic          halted;
    logic [CW-1:0] retired;
    logic          err;

    modport slave (
        input  in_valid, in_regwrite, in_wbsel, in_wreg, in_alu, in_pc2,
               in_imm, in_halt, dmem_done, dmem_data,
               rd1sel, rd2sel, rd1_rf, rd2_rf,
        output in_ready, write, writeregsel, writedata,
               rd1_fwd, rd2_fwd, halted, retired, err
    );

    modport master (
        output in_valid, in_regwrite, in_wbsel, in_wreg, in_alu, in_pc2,
               in_imm, in_halt, dmem_done, dmem_data,
               rd1sel, rd2sel, rd1_rf, rd2_rf,
        input  in_ready, write, writeregsel, writedata,
               rd1_fwd, rd2_fwd, halted, retired, err
    );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : 16-bit pipeline writeback stage: MEM/WB register, writeback mux,
//            register-file write port, same-cycle bypass, halt/retire/error.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int DW = 16,
    parameter int RW = 3,
    parameter int CW = 16
) (
    input  wire logic  clk,
    input  wire logic  rst,
    wb_stage_if.slave  bus
);

    localparam logic [1:0] c_sel_alu = 2'd0;
    localparam logic [1:0] c_sel_mem = 2'd1;
    localparam logic [1:0] c_sel_pc2 = 2'd2;
    localparam logic [1:0] c_sel_imm = 2'd3;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_v;
    logic          r_regwrite;
    logic [1:0]    r_wbsel;
    logic [RW-1:0] r_wreg;
    logic [DW-1:0] r_alu;
    logic [DW-1:0] r_pc2;
    logic [DW-1:0] r_imm;
    logic          r_halt;
    logic [CW-1:0] r_retired;
    logic          r_err;

    logic          w_halted;
    logic          w_commit;
    logic          w_ready;
    logic          w_accept;
    logic          w_write;
    logic [DW-1:0] w_wdata;

    assign w_halted = (r_state == ST_HALTED);

    // An entry caught on the halting edge stays parked: nothing commits once halted.
    assign w_commit = r_v && !w_halted && ((r_wbsel != c_sel_mem) || bus.dmem_done);
    assign w_ready  = !w_halted && (!r_v || w_commit);
    assign w_accept = bus.in_valid && w_ready;
    assign w_write  = w_commit && r_regwrite && (r_wbsel != c_sel_imm);

    always_comb begin
        w_wdata = r_alu;
        case (r_wbsel)
            c_sel_alu: w_wdata = r_alu;
            c_sel_mem: w_wdata = bus.dmem_data;
            c_sel_pc2: w_wdata = r_pc2;
            c_sel_imm: w_wdata = r_imm;
            default:   w_wdata = r_alu;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (w_commit && r_halt) w_state_nxt = ST_HALTED;
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_v       <= 1'b0;
            r_retired <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_v <= 1'b1;
            end else if (w_commit) begin
                r_v <= 1'b0;
            end
            if (w_commit) begin
                r_retired <= r_retired + CW'(1);
            end
            if (w_commit && r_regwrite && (r_wbsel == c_sel_imm)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Payload is qualified by r_v, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_regwrite <= bus.in_regwrite;
            r_wbsel    <= bus.in_wbsel;
            r_wreg     <= bus.in_wreg;
            r_alu      <= bus.in_alu;
            r_pc2      <= bus.in_pc2;
            r_imm      <= bus.in_imm;
            r_halt     <= bus.in_halt;
        end
    end

    assign bus.in_ready    = w_ready;
    assign bus.write       = w_write;
    assign bus.writeregsel = r_wreg;
    assign bus.writedata   = w_wdata;

    // The register file returns the old value while it is being written.
    assign bus.rd1_fwd = (w_write && (r_wreg == bus.rd1sel)) ? w_wdata : bus.rd1_rf;
    assign bus.rd2_fwd = (w_write && (r_wreg == bus.rd2sel)) ? w_wdata : bus.rd2_rf;

    assign bus.halted  = w_halted;
    assign bus.retired = r_retired;
    assign bus.err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Self-checking bench for wb_stage: directed scenarios plus random
//            traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    localparam int DW = 16;
    localparam int RW = 3;
    localparam int CW = 16;

    typedef struct packed {
        logic        regwrite;
        logic [1:0]  wbsel;
        logic [2:0]  wreg;
        logic [15:0] alu;
        logic [15:0] pc2;
        logic [15:0] imm;
        logic        halt;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_stage_if #(.DW(DW), .RW(RW), .CW(CW)) bus ();

    wb_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // reference model state
    ent_t        pend[$];
    logic        m_halted = 1'b0;
    logic [15:0] m_retired = 16'h0;
    logic        m_err = 1'b0;
    logic        s_commit;
    logic        s_accept;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ent_t cur_entry();
        ent_t e;
        e.regwrite = bus.in_regwrite;
        e.wbsel    = bus.in_wbsel;
        e.wreg     = bus.in_wreg;
        e.alu      = bus.in_alu;
        e.pc2      = bus.in_pc2;
        e.imm      = bus.in_imm;
        e.halt     = bus.in_halt;
        return e;
    endfunction

    task automatic idle();
        bus.in_valid    = 1'b0;
        bus.in_regwrite = 1'b0;
        bus.in_wbsel    = 2'd0;
        bus.in_wreg     = 3'd0;
        bus.in_alu      = 16'h0;
        bus.in_pc2      = 16'h0;
        bus.in_imm      = 16'h0;
        bus.in_halt     = 1'b0;
        bus.dmem_done   = 1'b0;
        bus.dmem_data   = 16'h0;
        bus.rd1sel      = 3'd0;
        bus.rd2sel      = 3'd0;
        bus.rd1_rf      = 16'h0;
        bus.rd2_rf      = 16'h0;
    endtask

    task automatic ins(input logic rw, input logic [1:0] sel, input logic [2:0] r,
                       input logic [15:0] alu, input logic [15:0] pc2,
                       input logic [15:0] imm, input logic hlt);
        bus.in_valid    = 1'b1;
        bus.in_regwrite = rw;
        bus.in_wbsel    = sel;
        bus.in_wreg     = r;
        bus.in_alu      = alu;
        bus.in_pc2      = pc2;
        bus.in_imm      = imm;
        bus.in_halt     = hlt;
    endtask

    // Mid-cycle: derive what the stage must show from the pending-instruction queue.
    task automatic settle(input bit do_chk);
        ent_t        head;
        logic        has;
        logic        e_ready;
        logic        e_write;
        logic [15:0] e_data;
        @(negedge clk);
        has  = (pend.size() != 0) && !m_halted;
        head = (pend.size() != 0) ? pend[0] : '0;
        s_commit = has && ((head.wbsel != 2'd1) || bus.dmem_done);
        e_ready  = !m_halted && ((pend.size() == 0) || s_commit);
        s_accept = bus.in_valid && e_ready;
        e_write  = s_commit && head.regwrite && (head.wbsel != 2'd3);
        case (head.wbsel)
            2'd0:    e_data = head.alu;
            2'd1:    e_data = bus.dmem_data;
            2'd2:    e_data = head.pc2;
            default: e_data = head.imm;
        endcase
        if (do_chk) begin
            check("in_ready", bus.in_ready, e_ready);
            check("write", bus.write, e_write);
            if (e_write) begin
                check("writeregsel", bus.writeregsel, head.wreg);
                check("writedata", bus.writedata, e_data);
            end
            check("rd1_fwd", bus.rd1_fwd,
                  (e_write && head.wreg == bus.rd1sel) ? e_data : bus.rd1_rf);
            check("rd2_fwd", bus.rd2_fwd,
                  (e_write && head.wreg == bus.rd2sel) ? e_data : bus.rd2_rf);
            check("halted", bus.halted, m_halted);
            check("retired", bus.retired, m_retired);
            check("err", bus.err, m_err);
        end
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (!rst) begin
            pend.delete();
            m_halted  = 1'b0;
            m_retired = 16'h0;
            m_err     = 1'b0;
        end else begin
            if (s_commit) begin
                e = pend.pop_front();
                m_retired = m_retired + 16'h1;
                if (e.regwrite && e.wbsel == 2'd3) m_err = 1'b1;
                if (e.halt) m_halted = 1'b1;
            end
            if (s_accept) pend.push_back(cur_entry());
        end
        #1;
    endtask

    task automatic cycle(input bit do_chk);
        settle(do_chk);
        tick();
    endtask

    initial begin
        idle();
        // reset held two cycles with traffic offered
        rst = 1'b0;
        ins(1'b1, 2'd0, 3'd6, 16'hDEAD, 16'h0, 16'h0, 1'b0);
        cycle(1'b0);
        cycle(1'b1);
        rst = 1'b1;

        // back-to-back ALU writes
        ins(1'b1, 2'd0, 3'd3, 16'h1234, 16'h0, 16'h0, 1'b0);
        settle(1'b1);
        check("rst_write", bus.write, 1'b0);
        check("rst_retired", bus.retired, 16'h0);
        check("rst_halted", bus.halted, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_ready", bus.in_ready, 1'b1);
        tick();
        ins(1'b1, 2'd0, 3'd5, 16'h00FF, 16'h0, 16'h0, 1'b0);
        settle(1'b1);
        check("b2b_w1", bus.write, 1'b1);
        check("b2b_sel1", bus.writeregsel, 3'd3);
        check("b2b_dat1", bus.writedata, 16'h1234);
        check("b2b_rdy1", bus.in_ready, 1'b1);
        tick();
        idle();
        settle(1'b1);
        check("b2b_w2", bus.write, 1'b1);
        check("b2b_sel2", bus.writeregsel, 3'd5);
        check("b2b_dat2", bus.writedata, 16'h00FF);
        tick();

        // load waits for dmem_done
        ins(1'b1, 2'd1, 3'd2, 16'h5555, 16'h0, 16'h0, 1'b0);
        settle(1'b1);
        check("b2b_retired", bus.retired, 16'd2);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            settle(1'b1);
            check("ld_wait_rdy", bus.in_ready, 1'b0);
            check("ld_wait_w", bus.write, 1'b0);
            tick();
        end
        bus.dmem_done = 1'b1;
        bus.dmem_data = 16'hBEEF;
        settle(1'b1);
        check("ld_w", bus.write, 1'b1);
        check("ld_sel", bus.writeregsel, 3'd2);
        check("ld_dat", bus.writedata, 16'hBEEF);
        check("ld_rdy", bus.in_ready, 1'b1);
        tick();

        // bypass
        idle();
        ins(1'b1, 2'd0, 3'd4, 16'hA5A5, 16'h0, 16'h0, 1'b0);
        cycle(1'b1);
        idle();
        bus.rd1sel = 3'd4; bus.rd2sel = 3'd1;
        bus.rd1_rf = 16'h0000; bus.rd2_rf = 16'h1111;
        settle(1'b1);
        check("byp_rd1", bus.rd1_fwd, 16'hA5A5);
        check("byp_rd2", bus.rd2_fwd, 16'h1111);
        tick();
        settle(1'b1);
        check("byp_none", bus.rd1_fwd, 16'h0000);
        tick();

        // halt
        rst = 1'b0;
        idle();
        cycle(1'b1);
        rst = 1'b1;
        ins(1'b1, 2'd2, 3'd7, 16'h0, 16'h0040, 16'h0, 1'b1);
        cycle(1'b1);
        ins(1'b1, 2'd0, 3'd1, 16'h7777, 16'h0, 16'h0, 1'b0);
        settle(1'b1);
        check("hlt_w", bus.write, 1'b1);
        check("hlt_sel", bus.writeregsel, 3'd7);
        check("hlt_dat", bus.writedata, 16'h0040);
        tick();
        for (int i = 0; i < 5; i++) begin
            settle(1'b1);
            check("hlt_halted", bus.halted, 1'b1);
            check("hlt_rdy", bus.in_ready, 1'b0);
            check("hlt_w_off", bus.write, 1'b0);
            check("hlt_retired", bus.retired, 16'd1);
            tick();
        end

        // random traffic against the model
        rst = 1'b0;
        idle();
        cycle(1'b1);
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 79) != 0);
            bus.in_valid    = 1'($urandom_range(0, 3) != 0);
            bus.in_regwrite = 1'($urandom_range(0, 1));
            bus.in_wbsel    = 2'($urandom_range(0, 3));
            bus.in_wreg     = 3'($urandom_range(0, 7));
            bus.in_alu      = 16'($urandom);
            bus.in_pc2      = 16'($urandom);
            bus.in_imm      = 16'($urandom);
            bus.in_halt     = 1'($urandom_range(0, 39) == 0);
            bus.dmem_done   = 1'($urandom_range(0, 2) == 0);
            bus.dmem_data   = 16'($urandom);
            bus.rd1sel      = 3'($urandom_range(0, 7));
            bus.rd2sel      = 3'($urandom_range(0, 7));
            bus.rd1_rf      = 16'($urandom);
            bus.rd2_rf      = 16'($urandom);
            cycle(1'b1);
        end

        // counter wrap with an illegal writeback
        rst = 1'b0;
        idle();
        cycle(1'b1);
        rst = 1'b1;
        ins(1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 65535; i++) cycle(1'b0);
        ins(1'b1, 2'd3, 3'd6, 16'h0, 16'h0, 16'h9999, 1'b0);
        settle(1'b1);
        check("wrap_pre", bus.retired, 16'hFFFE);
        tick();
        idle();
        settle(1'b1);
        check("ill_write", bus.write, 1'b0);
        check("ill_retired", bus.retired, 16'hFFFF);
        check("ill_err_pre", bus.err, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle(1'b1);
            check("ill_err", bus.err, 1'b1);
            check("wrap_retired", bus.retired, 16'h0000);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
